// File: rtl/pipeline_equiv_checker_pkg.sv
// ============================================================================
// Module      : pipeline_equiv_checker_pkg
// Description : Shared state encoding for the pipelined equivalence checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_equiv_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_equiv_checker_tagged_delay_line.sv
// ============================================================================
// Module      : tagged_delay_line
// Description : DEPTH-stage shift register carrying a valid tag with each word;
//               synchronous flush, pure pass-through when DEPTH is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tagged_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_flush};
            assign o_valid  = i_valid;
            assign o_data   = i_data;
        end else begin : g_stages
            logic [DEPTH-1:0] r_valid;
            logic [WIDTH-1:0] r_data [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    // Flush only kills the tags; stale data behind a cleared tag is harmless.
                    r_valid[0] <= i_valid & ~i_flush;
                    r_data[0]  <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1] & ~i_flush;
                        r_data[i]  <= r_data[i-1];
                    end
                end
            end

            assign o_valid = r_valid[DEPTH-1];
            assign o_data  = r_data[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/pipeline_equiv_checker.sv
// ============================================================================
// Module      : pipeline_equiv_checker
// Description : Drives every input vector into a reference and a test DUT,
//               compares their outputs after PIPELINE_DEPTH cycles and stops
//               on the first mismatch, latching the failing vector/outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_equiv_checker
    import pipeline_equiv_checker_pkg::*;
#(
    parameter int IN_W           = 2,
    parameter int OUT_W          = 1,
    parameter int PIPELINE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] gt_out,
    input  logic [OUT_W-1:0] test_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    num_checked,
    output logic [IN_W-1:0]  fail_vector,
    output logic [OUT_W-1:0] fail_expected,
    output logic [OUT_W-1:0] fail_actual
);

    localparam logic [IN_W:0]   c_NUM_VEC  = {1'b1, {IN_W{1'b0}}};
    localparam logic [IN_W:0]   c_ONE      = {{IN_W{1'b0}}, 1'b1};
    localparam logic [IN_W-1:0] c_LAST_VEC = '1;

    state_t             r_state;
    logic [IN_W:0]      r_cnt;
    logic [IN_W-1:0]    r_stim;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [IN_W:0]      r_num_checked;
    logic [IN_W-1:0]    r_fail_vector;
    logic [OUT_W-1:0]   r_fail_expected;
    logic [OUT_W-1:0]   r_fail_actual;

    logic               w_dl_valid;
    logic [IN_W-1:0]    w_dl_vec;
    logic               w_compare;
    logic               w_mismatch;
    logic               w_flush;

    tagged_delay_line #(
        .WIDTH (IN_W),
        .DEPTH (PIPELINE_DEPTH)
    ) u_delay_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_valid (r_state == ST_DRIVE),
        .i_data  (r_stim),
        .o_valid (w_dl_valid),
        .o_data  (w_dl_vec)
    );

    assign w_compare  = ((r_state == ST_DRIVE) || (r_state == ST_DRAIN)) && w_dl_valid;
    // Unknown bits on either bus count as a mismatch so an X never slips through as equal.
    assign w_mismatch = (gt_out != test_out) || $isunknown({gt_out, test_out});
    assign w_flush    = w_compare && w_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_stim          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_num_checked   <= '0;
            r_fail_vector   <= '0;
            r_fail_expected <= '0;
            r_fail_actual   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state         <= ST_DRIVE;
                        r_cnt           <= c_ONE;
                        r_stim          <= '0;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                        r_num_checked   <= '0;
                        r_fail_vector   <= '0;
                        r_fail_expected <= '0;
                        r_fail_actual   <= '0;
                    end
                end
                ST_DRIVE, ST_DRAIN: begin
                    if (r_state == ST_DRIVE) begin
                        if (r_cnt == c_NUM_VEC) begin
                            r_state <= ST_DRAIN;
                            r_stim  <= '0;
                        end else begin
                            r_stim <= r_cnt[IN_W-1:0];
                            r_cnt  <= r_cnt + c_ONE;
                        end
                    end
                    // A finishing comparison overrides the drive/drain advance above.
                    if (w_compare) begin
                        if (r_num_checked != c_NUM_VEC) begin
                            r_num_checked <= r_num_checked + c_ONE;
                        end
                        if (w_mismatch) begin
                            r_state         <= ST_DONE;
                            r_stim          <= '0;
                            r_busy          <= 1'b0;
                            r_done          <= 1'b1;
                            r_pass          <= 1'b0;
                            r_fail_vector   <= w_dl_vec;
                            r_fail_expected <= gt_out;
                            r_fail_actual   <= test_out;
                        end else if (w_dl_vec == c_LAST_VEC) begin
                            r_state <= ST_DONE;
                            r_stim  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim          = r_stim;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign num_checked   = r_num_checked;
    assign fail_vector   = r_fail_vector;
    assign fail_expected = r_fail_expected;
    assign fail_actual   = r_fail_actual;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_equiv_checker.sv
// ============================================================================
// Module      : tb_pipeline_equiv_checker
// Description : Directed bench with two checker instances (2-stage and
//               combinational) driving small reference/test models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_equiv_checker;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors;
    int n_miscompares;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: IN_W=2, OUT_W=1, depth 2 ----------------
    logic       start_a;
    logic [1:0] stim_a;
    logic       gt_a, test_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] num_a;
    logic [1:0] fv_a;
    logic       fe_a, fa_a;
    int         mode_a;
    logic       gt_r0, gt_r1, ts_r0, ts_r1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_r0 <= 1'b0; gt_r1 <= 1'b0; ts_r0 <= 1'b0; ts_r1 <= 1'b0;
        end else begin
            gt_r0 <= stim_a[1] & stim_a[0];
            gt_r1 <= gt_r0;
            case (mode_a)
                1:       ts_r0 <= ~stim_a[1] | ~stim_a[0];
                2:       ts_r0 <= (stim_a == 2'd3) ? 1'b0 : (stim_a[1] & stim_a[0]);
                default: ts_r0 <= stim_a[1] & stim_a[0];
            endcase
            ts_r1 <= ts_r0;
        end
    end
    assign gt_a   = gt_r1;
    assign test_a = ts_r1;

    pipeline_equiv_checker #(.IN_W(2), .OUT_W(1), .PIPELINE_DEPTH(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a),
        .gt_out(gt_a), .test_out(test_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .num_checked(num_a), .fail_vector(fv_a),
        .fail_expected(fe_a), .fail_actual(fa_a)
    );

    // ---------------- instance B: IN_W=3, combinational XOR vs XNOR ----------------
    logic       start_b;
    logic [2:0] stim_b;
    logic       gt_b, test_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] num_b;
    logic [2:0] fv_b;
    logic       fe_b, fa_b;

    assign gt_b   = ^stim_b;
    assign test_b = ~^stim_b;

    pipeline_equiv_checker #(.IN_W(3), .OUT_W(1), .PIPELINE_DEPTH(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b),
        .gt_out(gt_b), .test_out(test_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .num_checked(num_b), .fail_vector(fv_b),
        .fail_expected(fe_b), .fail_actual(fa_b)
    );

    // Start a run on A holding start for 'hold' sampled edges; n = edge index at which done is seen.
    task automatic run_a(input int hold, output int n);
        @(negedge clk);
        start_a = 1'b1;
        n = 0;
        @(posedge clk);
        #1;
        check_eq("a_e0_stim", stim_a, 0);
        check_eq("a_e0_busy", busy_a, 1);
        check_eq("a_e0_done", done_a, 0);
        check_eq("a_e0_num",  num_a, 0);
        check_eq("a_e0_fail", {fv_a, fe_a, fa_a}, 0);
        while (n < 50) begin
            @(negedge clk);
            start_a = (hold > n + 1);
            @(posedge clk);
            n++;
            #1;
            check_eq("a_busy_done_excl", busy_a & done_a, 0);
            if (done_a) break;
            if (n < 4) check_eq("a_stim_seq", stim_a, n);
        end
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic check_a(input string tag, input int n, input int n_exp, input logic p,
                           input logic [2:0] num, input logic [1:0] fv, input logic fe, input logic fa);
        check_eq({tag, "_done_edge"}, n, n_exp);
        check_eq({tag, "_pass"}, pass_a, p);
        check_eq({tag, "_num"}, num_a, num);
        check_eq({tag, "_fvec"}, fv_a, fv);
        check_eq({tag, "_fexp"}, fe_a, fe);
        check_eq({tag, "_fact"}, fa_a, fa);
        check_eq({tag, "_busy"}, busy_a, 0);
    endtask

    initial begin
        int n;
        int n2;
        logic [7:0] snap;
        n_vectors     = 0;
        n_miscompares = 0;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs_a", {stim_a, busy_a, done_a, pass_a, num_a, fv_a, fe_a, fa_a}, 0);
        check_eq("rst_outputs_b", {stim_b, busy_b, done_b, pass_b, num_b, fv_b, fe_b, fa_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identical DUTs: full pass after E6
        mode_a = 0;
        run_a(1, n);
        check_a("match", n, 6, 1'b1, 3'd4, 2'd0, 1'b0, 1'b0);

        // Wrong for every vector: fails on vector 0 at E3
        mode_a = 1;
        run_a(1, n);
        check_a("fail_v0", n, 3, 1'b0, 3'd1, 2'd0, 1'b0, 1'b1);

        // Wrong only for input 3: fails at E6 after four comparisons
        mode_a = 2;
        run_a(1, n);
        check_a("fail_v3", n, 6, 1'b0, 3'd4, 2'd3, 1'b1, 1'b0);

        // Combinational XOR vs XNOR on instance B: fails on vector 0 at E1
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        check_eq("b_e0_busy", busy_b, 1);
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (done_b) break;
        end
        check_eq("b_done_edge", n, 1);
        check_eq("b_pass", pass_b, 0);
        check_eq("b_num", num_b, 1);
        check_eq("b_fvec", fv_b, 0);
        check_eq("b_fexp", fe_b, 0);
        check_eq("b_fact", fa_b, 1);

        // Asynchronous reset in the middle of a run
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_a", {stim_a, busy_a, done_a, pass_a, num_a, fv_a, fe_a, fa_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a(1, n);
        check_a("after_rst", n, 6, 1'b1, 3'd4, 2'd0, 1'b0, 1'b0);

        // start held for 3 cycles, then restart from DONE
        mode_a = 2;
        run_a(3, n);
        check_a("held_start", n, 6, 1'b0, 3'd4, 2'd3, 1'b1, 1'b0);
        snap = {pass_a, num_a, fv_a, fe_a, fa_a};
        run_a(1, n2);
        check_eq("restart_edge", n2, n);
        check_eq("restart_same", {pass_a, num_a, fv_a, fe_a, fa_a}, snap);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
